quick_queue_heap: RTL and testbench

Parametrised hardware priority queue built as a binary heap in a two-port memory (1 write, 1 sync read). Generalises the quick queue to arbitrary width and depth, with a selectable min/max ordering and a single-operation replace (enq+deq) path. It also gives explicit full, empty, count and error status. Sits where the quick queue top sits: the scheduler side issues enq/deq and reads the current top from data_o.

---
 rtl/quick_queue_heap_pkg.sv | 40 ++++
 rtl/mem2p_sw_sr.sv | 32 +++
 rtl/quick_queue_heap_index_unit.sv | 30 +++
 rtl/quick_queue_heap.sv | 228 ++++++++++++++++++++++
 tb/tb_quick_queue_heap.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/quick_queue_heap_pkg.sv
`default_nettype none
// ============================================================================
// quick_queue_heap_pkg : heap FSM states, key ordering and heap index helpers
// Revision: 1.0
// ============================================================================
package quick_queue_heap_pkg;

    // Keys are zero-extended to this width before comparison; W must not exceed it.
    localparam int MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP_RD   = 3'd1,
        UP_CMP  = 3'd2,
        DN_LAST = 3'd3,
        DN_RDL  = 3'd4,
        DN_RDR  = 3'd5,
        DN_CMP  = 3'd6
    } heapState_t;

    function automatic logic better(input logic [MAX_W-1:0] a,
                                    input logic [MAX_W-1:0] b,
                                    input logic             min_first);
        return min_first ? (a < b) : (a > b);
    endfunction

    function automatic logic [31:0] parent_idx(input logic [31:0] i);
        return (i - 32'd1) >> 1;
    endfunction

    function automatic logic [31:0] left_idx(input logic [31:0] i);
        return (i << 1) + 32'd1;
    endfunction

    function automatic logic [31:0] right_idx(input logic [31:0] i);
        return (i << 1) + 32'd2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem2p_sw_sr.sv
`default_nettype none
// ============================================================================
// mem2p_sw_sr : two-port RAM, one synchronous write port, one registered read
// Revision: 1.0
// ============================================================================
module mem2p_sw_sr #(
    parameter int W  = 32,
    parameter int D  = 16,
    parameter int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [D];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/quick_queue_heap_index_unit.sv
`default_nettype none
// ============================================================================
// heap_index_unit : parent/child addresses of the current hole and bound checks
// Revision: 1.0
// ============================================================================
module heap_index_unit
    import quick_queue_heap_pkg::*;
#(
    parameter int D  = 16,
    parameter int AW = $clog2(D),
    parameter int CW = $clog2(D + 1)
) (
    input  logic [AW-1:0] hole,
    input  logic [CW-1:0] count,
    output logic [AW-1:0] parent,
    output logic [AW-1:0] left,
    output logic [AW-1:0] right,
    output logic          left_ok,
    output logic          right_ok
);

    // Child indices are checked at 32 bits so 2*hole+2 never wraps before the compare.
    assign parent   = AW'(parent_idx(32'(hole)));
    assign left     = AW'(left_idx(32'(hole)));
    assign right    = AW'(right_idx(32'(hole)));
    assign left_ok  = left_idx(32'(hole))  < 32'(count);
    assign right_ok = right_idx(32'(hole)) < 32'(count);

endmodule
`default_nettype wire

// File: rtl/quick_queue_heap.sv
`default_nettype none
// ============================================================================
// quick_queue_heap : binary-heap priority queue with enq, deq and replace
// Revision: 1.0
// ============================================================================
module quick_queue_heap
    import quick_queue_heap_pkg::*;
#(
    parameter int W         = 32,
    parameter int D         = 16,
    parameter int MIN_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enq,
    input  logic                   deq,
    input  logic [W-1:0]           data_i,
    output logic                   ready,
    output logic [W-1:0]           data_o,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(D+1)-1:0] count,
    output logic                   error
);

    localparam int AW = $clog2(D);
    localparam int CW = $clog2(D + 1);

    heapState_t    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] hole_q, hole_d;
    logic [W-1:0]  mv_q, mv_d;
    logic [W-1:0]  lc_q, lc_d;
    logic [W-1:0]  top_q, top_d;
    logic          has_r_q, has_r_d;
    logic          error_q, error_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [W-1:0]  mem_wdata;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic [W-1:0]  mem_rdata;

    logic [AW-1:0] idx_parent, idx_left, idx_right;
    logic          left_ok, right_ok;

    logic [W-1:0]  child_key;
    logic [AW-1:0] child_idx;

    function automatic logic bt(input logic [W-1:0] a, input logic [W-1:0] b);
        return better(MAX_W'(a), MAX_W'(b), MIN_FIRST != 0);
    endfunction

    mem2p_sw_sr #(.W(W), .D(D), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    heap_index_unit #(.D(D), .AW(AW), .CW(CW)) u_idx (
        .hole     (hole_q),
        .count    (count_q),
        .parent   (idx_parent),
        .left     (idx_left),
        .right    (idx_right),
        .left_ok  (left_ok),
        .right_ok (right_ok)
    );

    // In DN_CMP rdata still holds the left child when no right read was issued.
    always_comb begin
        if (has_r_q && bt(mem_rdata, lc_q)) begin
            child_key = mem_rdata;
            child_idx = idx_right;
        end else begin
            child_key = lc_q;
            child_idx = idx_left;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hole_d    = hole_q;
        mv_d      = mv_q;
        lc_d      = lc_q;
        has_r_d   = has_r_q;
        error_d   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = hole_q;
        mem_wdata = mv_q;
        mem_re    = 1'b0;
        mem_raddr = idx_left;

        case (state_q)
            IDLE: begin
                if (enq && deq && !empty_q) begin
                    mv_d    = data_i;
                    hole_d  = '0;
                    state_d = DN_RDL;
                end else if (enq) begin
                    // A deq paired with an enq on an empty queue is dropped and flagged.
                    error_d = deq;
                    if (full_q) begin
                        error_d = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                        hole_d  = AW'(count_q);
                        mv_d    = data_i;
                        state_d = UP_RD;
                    end
                end else if (deq) begin
                    if (empty_q) begin
                        error_d = 1'b1;
                    end else begin
                        count_d = count_q - CW'(1);
                        hole_d  = '0;
                        if (count_q != CW'(1)) begin
                            mem_re    = 1'b1;
                            mem_raddr = AW'(count_q - CW'(1));
                            state_d   = DN_LAST;
                        end
                    end
                end
            end
            UP_RD: begin
                if (hole_q == '0) begin
                    mem_we  = 1'b1;
                    state_d = IDLE;
                end else begin
                    mem_re    = 1'b1;
                    mem_raddr = idx_parent;
                    state_d   = UP_CMP;
                end
            end
            UP_CMP: begin
                mem_we = 1'b1;
                if (bt(mv_q, mem_rdata)) begin
                    mem_wdata = mem_rdata;
                    hole_d    = idx_parent;
                    state_d   = UP_RD;
                end else begin
                    state_d = IDLE;
                end
            end
            DN_LAST: begin
                mv_d    = mem_rdata;
                state_d = DN_RDL;
            end
            DN_RDL: begin
                if (!left_ok) begin
                    mem_we  = 1'b1;
                    state_d = IDLE;
                end else begin
                    mem_re    = 1'b1;
                    mem_raddr = idx_left;
                    state_d   = DN_RDR;
                end
            end
            DN_RDR: begin
                lc_d    = mem_rdata;
                has_r_d = right_ok;
                if (right_ok) begin
                    mem_re    = 1'b1;
                    mem_raddr = idx_right;
                end
                state_d = DN_CMP;
            end
            DN_CMP: begin
                mem_we = 1'b1;
                if (bt(child_key, mv_q)) begin
                    mem_wdata = child_key;
                    hole_d    = child_idx;
                    state_d   = DN_RDL;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        top_d   = (mem_we && mem_waddr == '0) ? mem_wdata : top_q;
        full_d  = (count_d == CW'(D));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            hole_q  <= '0;
            mv_q    <= '0;
            lc_q    <= '0;
            top_q   <= '0;
            has_r_q <= 1'b0;
            error_q <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hole_q  <= hole_d;
            mv_q    <= mv_d;
            lc_q    <= lc_d;
            top_q   <= top_d;
            has_r_q <= has_r_d;
            error_q <= error_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign data_o = top_q;
    assign empty  = empty_q;
    assign full   = full_q;
    assign count  = count_q;
    assign error  = error_q;

endmodule
`default_nettype wire

// File: tb/tb_quick_queue_heap.sv
`default_nettype none
// ============================================================================
// tb_quick_queue_heap : min-heap and max-heap instances checked against a multiset model
// Revision: 1.0
// ============================================================================
module tb_quick_queue_heap;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int CW = $clog2(D + 1);
    localparam int ENQ_BOUND = 2 * $clog2(D) + 1;
    localparam int DEQ_BOUND = 3 * $clog2(D) + 2;

    logic          clk = 1'b0;
    logic          rst   [2];
    logic          enq   [2];
    logic          deq   [2];
    logic [W-1:0]  din   [2];
    logic          ready [2];
    logic [W-1:0]  dout  [2];
    logic          empty [2];
    logic          full  [2];
    logic [CW-1:0] cnt   [2];
    logic          error [2];

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] mq [2][$];

    always #5 clk = ~clk;

    quick_queue_heap #(.W(W), .D(D), .MIN_FIRST(1)) u_min (
        .clk(clk), .rst(rst[0]), .enq(enq[0]), .deq(deq[0]), .data_i(din[0]),
        .ready(ready[0]), .data_o(dout[0]), .empty(empty[0]), .full(full[0]),
        .count(cnt[0]), .error(error[0])
    );

    quick_queue_heap #(.W(W), .D(D), .MIN_FIRST(0)) u_max (
        .clk(clk), .rst(rst[1]), .enq(enq[1]), .deq(deq[1]), .data_i(din[1]),
        .ready(ready[1]), .data_o(dout[1]), .empty(empty[1]), .full(full[1]),
        .count(cnt[1]), .error(error[1])
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Instance 0 is the min-heap, instance 1 the max-heap.
    function automatic int best_pos(input int s);
        int p = 0;
        for (int i = 1; i < mq[s].size(); i++) begin
            if (s == 0 ? (mq[s][i] < mq[s][p]) : (mq[s][i] > mq[s][p])) p = i;
        end
        return p;
    endfunction

    task automatic check_status(input int s);
        chk("count", 32'(cnt[s]), 32'(mq[s].size()));
        chk("empty", 32'(empty[s]), 32'(mq[s].size() == 0));
        chk("full", 32'(full[s]), 32'(mq[s].size() == D));
        chk("ready", 32'(ready[s]), 32'd1);
        if (mq[s].size() > 0) chk("top", dout[s], mq[s][best_pos(s)]);
    endtask

    task automatic op(input int s, input bit e, input bit d, input logic [W-1:0] v);
        bit exp_err = 1'b0;
        int bound   = 0;
        int cyc     = 0;
        @(negedge clk);
        enq[s] = e;
        deq[s] = d;
        din[s] = v;
        if (e && d && mq[s].size() > 0) begin
            mq[s].delete(best_pos(s));
            mq[s].push_back(v);
            bound = DEQ_BOUND;
        end else if (e) begin
            exp_err = d;
            if (mq[s].size() == D) begin
                exp_err = 1'b1;
            end else begin
                mq[s].push_back(v);
                bound = ENQ_BOUND;
            end
        end else if (d) begin
            if (mq[s].size() == 0) begin
                exp_err = 1'b1;
            end else begin
                mq[s].delete(best_pos(s));
                bound = DEQ_BOUND;
            end
        end
        @(posedge clk);
        #1;
        enq[s] = 1'b0;
        deq[s] = 1'b0;
        chk("error", 32'(error[s]), 32'(exp_err));
        while (!ready[s] && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency_ok", 32'(cyc <= bound), 32'd1);
        if (exp_err) begin
            @(posedge clk);
            #1;
            chk("error_one_cycle", 32'(error[s]), 32'd0);
        end
        check_status(s);
    endtask

    task automatic do_reset(input int s);
        @(negedge clk);
        rst[s] = 1'b1;
        @(negedge clk);
        rst[s] = 1'b0;
        mq[s].delete();
        #1;
        chk("rst_ready", 32'(ready[s]), 32'd1);
        chk("rst_data_o", dout[s], 32'd0);
        chk("rst_error", 32'(error[s]), 32'd0);
        check_status(s);
    endtask

    task automatic rand_ops(input int s, input int n);
        int r;
        logic [W-1:0] k;
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 9));
            k = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 7)) : W'($urandom);
            if (r < 4)      op(s, 1'b1, 1'b0, k);
            else if (r < 7) op(s, 1'b0, 1'b1, k);
            else            op(s, 1'b1, 1'b1, k);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; enq[s] = 1'b0; deq[s] = 1'b0; din[s] = '0;
        end
        repeat (2) @(posedge clk);
        do_reset(0);
        do_reset(1);

        // Basic ordering on the min-heap
        op(0, 1, 0, 5); op(0, 1, 0, 3); op(0, 1, 0, 9); op(0, 1, 0, 1);
        chk("top_after_4", dout[0], 32'd1);
        for (int i = 0; i < 4; i++) op(0, 0, 1, 0);
        chk("drained_empty", 32'(empty[0]), 32'd1);

        // Fill to capacity, then overflow
        for (int i = 16; i >= 1; i--) op(0, 1, 0, W'(i));
        chk("full_top", dout[0], 32'd1);
        op(0, 1, 0, 100);
        chk("overflow_count", 32'(cnt[0]), 32'd16);
        for (int i = 0; i < 16; i++) op(0, 0, 1, 0);

        // Underflow and enq+deq on empty
        op(0, 0, 1, 0);
        op(0, 1, 1, 7);
        chk("enqdeq_empty_top", dout[0], 32'd7);
        op(0, 0, 1, 0);

        // Replace on a full queue
        for (int i = 1; i <= 16; i++) op(0, 1, 0, W'(i));
        op(0, 1, 1, 20);
        chk("replace_top", dout[0], 32'd2);
        for (int i = 0; i < 16; i++) op(0, 0, 1, 0);

        rand_ops(0, 300);

        // Reset landing in DN_CMP of a replace
        do_reset(0);
        op(0, 1, 0, 10); op(0, 1, 0, 20); op(0, 1, 0, 30);
        @(negedge clk);
        enq[0] = 1'b1; deq[0] = 1'b1; din[0] = 40;
        @(posedge clk);
        #1;
        enq[0] = 1'b0; deq[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst[0] = 1'b1;
        #1;
        chk("midrst_count", 32'(cnt[0]), 32'd0);
        @(negedge clk);
        rst[0] = 1'b0;
        mq[0].delete();
        @(posedge clk);
        #1;
        chk("midrst_ready", 32'(ready[0]), 32'd1);
        chk("midrst_empty", 32'(empty[0]), 32'd1);
        chk("midrst_data_o", dout[0], 32'd0);
        chk("midrst_error", 32'(error[0]), 32'd0);
        op(0, 1, 0, 5);
        chk("post_rst_top", dout[0], 32'd5);

        // Max-heap with equal keys
        op(1, 1, 0, 4); op(1, 1, 0, 8); op(1, 1, 0, 8); op(1, 1, 0, 2);
        chk("max_top", dout[1], 32'd8);
        for (int i = 0; i < 4; i++) op(1, 0, 1, 0);
        rand_ops(1, 300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
